// File: rtl/icache_2way_pkg.sv
// Shared encodings and default geometry for the 2-way instruction cache.
package icache_2way_pkg;

  // Default cache geometry: 64 sets, 4 words per line, 32-bit byte addresses.
  localparam int unsigned ICACHE_SETS_LOG2       = 6;
  localparam int unsigned ICACHE_LINE_WORDS_LOG2 = 2;
  localparam int unsigned ICACHE_ADDR_WIDTH      = 32;

  // Refill FSM state bus and encodings.
  typedef logic [1:0] icache_state_bus_t;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Tag width left over once offset, index and byte bits are removed.
  function automatic int unsigned icache_tag_width(input int unsigned addr_w,
                                                   input int unsigned sets_log2,
                                                   input int unsigned words_log2);
    return addr_w - sets_log2 - words_log2 - 2;
  endfunction

endpackage

// File: rtl/icache_way.sv
// Storage for one way: tag, valid and data arrays with one read and one write port.
module icache_way
  import icache_2way_pkg::*;
#(
  parameter int unsigned SETS_LOG2       = ICACHE_SETS_LOG2,
  parameter int unsigned LINE_WORDS_LOG2 = ICACHE_LINE_WORDS_LOG2,
  parameter int unsigned TAG_W           = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  // Read port
  input  logic [SETS_LOG2-1:0]       rd_index,
  input  logic [LINE_WORDS_LOG2-1:0] rd_offset,
  output logic [TAG_W-1:0]           rd_tag,
  output logic                       rd_valid,
  output logic [31:0]                rd_data,
  // Line word write port
  input  logic                       data_we,
  input  logic [SETS_LOG2-1:0]       wr_index,
  input  logic [LINE_WORDS_LOG2-1:0] wr_offset,
  input  logic [31:0]                wr_data,
  // Tag / valid write port
  input  logic                       tag_we,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic                       wr_valid,
  // Invalidate every line
  input  logic                       flush_all
);

  localparam int unsigned SETS  = 1 << SETS_LOG2;
  localparam int unsigned WORDS = 1 << LINE_WORDS_LOG2;

  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*WORDS];
  logic [SETS-1:0]  valid_q;

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

  // Valid bits: the only storage that needs a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  // Tag and data arrays are guarded by valid, so they are left unreset.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
    if (data_we) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with 1-bit LRU and its own refill FSM.
module icache_2way
  import icache_2way_pkg::*;
#(
  parameter int unsigned SETS_LOG2       = ICACHE_SETS_LOG2,
  parameter int unsigned LINE_WORDS_LOG2 = ICACHE_LINE_WORDS_LOG2,
  parameter int unsigned ADDR_WIDTH      = ICACHE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data
);

  localparam int unsigned OFF_W = LINE_WORDS_LOG2;
  localparam int unsigned IDX_W = SETS_LOG2;
  localparam int unsigned TAG_W = icache_tag_width(ADDR_WIDTH, SETS_LOG2, LINE_WORDS_LOG2);
  localparam int unsigned SETS  = 1 << SETS_LOG2;

  // Request address split
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_bits;

  assign req_off          = req_addr[OFF_W+1:2];
  assign req_idx          = req_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag          = req_addr[ADDR_WIDTH-1:IDX_W+OFF_W+2];
  assign unused_addr_bits = ^req_addr[1:0];

  // State
  icache_state_bus_t state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              victim_q, victim_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic              pend_q, pend_d;
  logic [31:0]       crit_q, crit_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_inst_q, resp_inst_d;

  // Way array interface
  logic [TAG_W-1:0] way_tag  [2];
  logic [31:0]      way_data [2];
  logic [1:0]       way_valid;
  logic [1:0]       hit;
  logic [1:0]       data_we;
  logic [1:0]       tag_we;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_valid;
  logic             flush_all;
  logic             miss_victim;

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way #(
      .SETS_LOG2      (SETS_LOG2),
      .LINE_WORDS_LOG2(LINE_WORDS_LOG2),
      .TAG_W          (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .rd_index (req_idx),
      .rd_offset(req_off),
      .rd_tag   (way_tag[w]),
      .rd_valid (way_valid[w]),
      .rd_data  (way_data[w]),
      .data_we  (data_we[w]),
      .wr_index (wr_idx),
      .wr_offset(cnt_q),
      .wr_data  (mem_data),
      .tag_we   (tag_we[w]),
      .wr_tag   (wr_tag),
      .wr_valid (wr_valid),
      .flush_all(flush_all)
    );
    assign hit[w] = way_valid[w] && (way_tag[w] == req_tag);
  end

  // First invalid way wins, otherwise the LRU way of the set.
  assign miss_victim = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_idx]);

  assign req_ready  = !rst && (state_q == IDLE) && !flush;
  assign mem_req    = (state_q == REFILL);
  assign mem_addr   = (state_q == REFILL) ? {tag_q, idx_q, cnt_q, 2'b00} : '0;
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;

  // Next-state, LRU update and array write control; everything holds while rdy is low.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    pend_d       = pend_q;
    crit_d       = crit_q;
    resp_valid_d = resp_valid_q;
    resp_inst_d  = resp_inst_q;
    data_we      = '0;
    tag_we       = '0;
    wr_idx       = idx_q;
    wr_tag       = tag_q;
    wr_valid     = 1'b0;
    flush_all    = 1'b0;

    if (rdy) begin
      resp_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (flush) begin
            flush_all = 1'b1;
            lru_d     = '0;
          end else if (req_valid) begin
            if (hit != 2'b00) begin
              resp_valid_d   = 1'b1;
              resp_inst_d    = hit[0] ? way_data[0] : way_data[1];
              lru_d[req_idx] = hit[0];
            end else begin
              // Drop the victim's valid bit now so a half-written line never hits.
              tag_we[miss_victim] = 1'b1;
              wr_idx              = req_idx;
              wr_tag              = req_tag;
              wr_valid            = 1'b0;
              tag_d               = req_tag;
              idx_d               = req_idx;
              off_d               = req_off;
              cnt_d               = '0;
              victim_d            = miss_victim;
              pend_d              = 1'b0;
              state_d             = REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) begin
            pend_d = 1'b1;
          end
          if (mem_ack) begin
            data_we[victim_q] = 1'b1;
            cnt_d             = cnt_q + 1'b1;
            if (cnt_q == off_q) begin
              crit_d = mem_data;
            end
            if (cnt_q == {OFF_W{1'b1}}) begin
              tag_we[victim_q] = 1'b1;
              wr_valid         = 1'b1;
              lru_d[idx_q]     = ~victim_q;
              resp_valid_d     = 1'b1;
              resp_inst_d      = (cnt_q == off_q) ? mem_data : crit_q;
              state_d          = RESP;
            end
          end
        end
        RESP: begin
          state_d = IDLE;
          if (pend_q || flush) begin
            flush_all = 1'b1;
            lru_d     = '0;
            pend_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      pend_q       <= 1'b0;
      crit_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      pend_q       <= pend_d;
      crit_q       <= crit_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: a true-LRU set model predicts hit/miss and data.
module tb_icache_2way;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;

  icache_2way dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_inst (resp_inst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Backing memory: a few preloaded words, a hash everywhere else.
  logic [31:0] mimg [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mimg.exists(a)) return mimg[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Reference model: per set, resident tags in recency order (index 0 = least recent).
  logic [21:0] mlist [64][2];
  int          mcnt  [64];

  function automatic void model_flush();
    for (int s = 0; s < 64; s++) mcnt[s] = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int          s;
    logic [21:0] t;
    s = int'(a[9:4]);
    t = a[31:10];
    if (mcnt[s] > 0 && mlist[s][mcnt[s]-1] == t) return 1'b0;
    if (mcnt[s] == 2 && mlist[s][0] == t) begin
      mlist[s][0] = mlist[s][1];
      mlist[s][1] = t;
      return 1'b0;
    end
    if (mcnt[s] < 2) begin
      mlist[s][mcnt[s]] = t;
      mcnt[s]++;
    end else begin
      mlist[s][0] = mlist[s][1];
      mlist[s][1] = t;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic [31:0] inst;
    bit          miss;
    logic [31:0] base;
    int          edge_c;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          edge_c;
  } ack_t;

  exp_t sbq  [$];
  ack_t ackq [$];

  bit          rand_rdy = 1'b0;
  bit          rand_ack = 1'b0;
  bit          stall_arm = 1'b0;
  int          stall_left = 0;
  int          stall_done = 0;
  int          ack_in_line = 0;
  logic [31:0] stall_addr = '0;

  // Environment: monitor responses, then drive rdy and the memory side for the next edge.
  always @(negedge clk) begin
    exp_t e;
    ack_t k;
    // A response counts only if the edge that produced it had rdy high.
    if (!rst && resp_valid && rdy) begin
      if (sbq.size() == 0) begin
        chk("resp_with_empty_scoreboard", {31'b0, resp_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("resp_inst", resp_inst, e.inst);
        chk("refill_words", ackq.size(), e.miss ? 32'd4 : 32'd0);
        if (e.miss && ackq.size() == 4) begin
          for (int i = 0; i < 4; i++) chk("refill_addr", ackq[i].addr, e.base + 32'(4 * i));
          chk("miss_latency", cyc, ackq[3].edge_c);
        end else if (!e.miss) begin
          chk("hit_latency", cyc, e.edge_c);
        end
      end
      ackq.delete();
    end
    if (stall_left > 0) begin
      rdy     = 1'b0;
      mem_ack = 1'b1;
      chk("stall_mem_addr", mem_addr, stall_addr);
      chk("stall_mem_req", {31'b0, mem_req}, 32'd1);
      stall_left--;
      stall_done++;
    end else begin
      rdy     = rand_rdy ? ($urandom_range(0, 4) != 0) : 1'b1;
      mem_ack = mem_req ? (!rand_ack || $urandom_range(0, 1) == 1)
                        : (rand_ack && $urandom_range(0, 9) == 0);
    end
    mem_data = mem_req ? mem_word(mem_addr) : $urandom;
    if (!rst && mem_req && mem_ack && rdy) begin
      k.addr   = mem_addr;
      k.edge_c = cyc + 1;
      ackq.push_back(k);
      ack_in_line = (ack_in_line + 1) % 4;
      if (stall_arm && ack_in_line == 2) begin
        stall_arm  = 1'b0;
        stall_left = 5;
        stall_addr = mem_addr + 32'd4;
      end
    end
  end

  // Present a request until accepted (bounded); expectation is pushed at acceptance.
  task automatic issue(input logic [31:0] a);
    bit   acc;
    exp_t e;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 400 && !acc; i++) begin
      #1;
      if (req_ready && rdy) begin
        acc      = 1'b1;
        e.miss   = model_access(a);
        e.inst   = mem_word({a[31:2], 2'b00});
        e.base   = {a[31:4], 4'h0};
        e.edge_c = cyc + 1;
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  // Hold flush until an edge with rdy high takes it.
  task automatic do_flush();
    flush = 1'b1;
    #1;
    for (int i = 0; i < 400 && !rdy; i++) begin
      @(negedge clk);
      #1;
    end
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    mimg[32'h1000] = 32'hA0;
    mimg[32'h1004] = 32'hA1;
    mimg[32'h1008] = 32'hA2;
    mimg[32'h100C] = 32'hA3;
    model_flush();

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_inst", resp_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // Cold miss, then back-to-back hits
    issue(32'h1004);
    drain();
    issue(32'h100C);
    issue(32'h1000);
    drain();

    // LRU replacement at index 0
    issue(32'h2000);
    issue(32'h1000);
    issue(32'h3000);
    issue(32'h1000);
    issue(32'h2000);
    drain();

    // Flush concurrent with a request in IDLE
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h1000;
    #1;
    chk("flush_blocks_req", {31'b0, req_ready}, 32'd0);
    model_flush();
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    issue(32'h1000);
    drain();

    // Flush while refilling
    issue(32'h1000);
    issue(32'h6000);
    @(negedge clk);
    #1;
    chk("flush_in_refill_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    do_flush();
    drain();
    issue(32'h6000);
    drain();

    // rdy stall after the second ack with mem_ack held
    stall_arm   = 1'b1;
    ack_in_line = 0;
    issue(32'h1008);
    drain();
    chk("stall_cycles", stall_done, 32'd5);

    // Asynchronous reset mid-refill
    issue(32'h5000);
    #1;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("async_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    sbq.delete();
    ackq.delete();
    ack_in_line = 0;
    model_flush();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    issue(32'h1000);
    drain();

    // Randomised traffic over a small address pool to force hits, evictions and flushes
    rand_rdy = 1'b1;
    rand_ack = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(1, 5)) << 10) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 19) == 0) do_flush();
      issue(a);
    end
    drain();
    chk("final_scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
